// File: rtl/register_sequencer.sv
// Instruction sequencer for the A/B data registers: turns 8-bit instructions into
// registered per-cycle op codes and load data, stalling the stream during multi-cycle shifts.
module register_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [7:0]            instr,
  output logic                  instr_ready,
  output logic [1:0]            op_a,
  output logic [1:0]            op_b,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error
);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_HOLD  = 2'b10;
  localparam logic [1:0] OP_SHL   = 2'b11;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic                  shift_b, shift_b_n;
  logic [1:0]            op_a_n, op_b_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  error_n;

  logic                  accept;
  logic [3:0]            opc;
  logic [3:0]            imm;
  logic [CNT_WIDTH-1:0]  shift_n;
  logic                  is_shl;

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid & instr_ready;
  assign opc         = instr[7:4];
  assign imm         = instr[3:0];
  assign shift_n     = CNT_WIDTH'(imm);
  assign is_shl      = (opc == 4'b0100) || (opc == 4'b0110);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shift_b  <= 1'b0;
      op_a     <= OP_CLEAR;
      op_b     <= OP_CLEAR;
      data_out <= '0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift_b  <= shift_b_n;
      op_a     <= op_a_n;
      op_b     <= op_b_n;
      data_out <= data_n;
      error    <= error_n;
    end
  end

  // Only shifts of two or more cycles need SHIFT; the last SHIFTL cycle is spent
  // back in IDLE so the next instruction can be accepted without a bubble.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shift_b_n = shift_b;
    case (state)
      IDLE: begin
        if (accept && is_shl && shift_n >= CNT_WIDTH'(2)) begin
          state_n   = SHIFT;
          cnt_n     = shift_n - CNT_WIDTH'(1);
          shift_b_n = (opc == 4'b0110);
        end
      end
      SHIFT: begin
        if (cnt == CNT_WIDTH'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    op_a_n  = OP_HOLD;
    op_b_n  = OP_HOLD;
    data_n  = data_out;
    error_n = error;
    if (state == SHIFT) begin
      if (shift_b) op_b_n = OP_SHL;
      else         op_a_n = OP_SHL;
    end else if (accept) begin
      case (opc)
        4'b0000: ;
        4'b0001: op_a_n = OP_CLEAR;
        4'b0010: begin op_a_n = OP_LOAD; data_n = DATA_WIDTH'(imm); end
        4'b0011: begin op_b_n = OP_LOAD; data_n = DATA_WIDTH'(imm); end
        4'b0100: if (imm != 4'd0) op_a_n = OP_SHL;
        4'b0101: op_b_n = OP_CLEAR;
        4'b0110: if (imm != 4'd0) op_b_n = OP_SHL;
        4'b0111: begin op_a_n = OP_CLEAR; op_b_n = OP_CLEAR; end
        default: error_n = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_register_sequencer.sv
// Directed scoreboard bench for register_sequencer: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_register_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_ready;
  logic [1:0] op_a, op_b;
  logic [3:0] data_out;
  logic       error;

  register_sequencer #(.DATA_WIDTH(4), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .op_a(op_a), .op_b(op_b),
    .data_out(data_out), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    int         tag;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] d;
    logic       e;
    logic       r;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   tag = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t x;
      x = q.pop_front();
      total = total + 1;
      if (op_a === x.a && op_b === x.b && data_out === x.d &&
          error === x.e && instr_ready === x.r)
        passed = passed + 1;
      else
        $display("FAIL step%0d: got a=%b b=%b d=%h e=%b r=%b, want a=%b b=%b d=%h e=%b r=%b",
                 x.tag, op_a, op_b, data_out, error, instr_ready,
                 x.a, x.b, x.d, x.e, x.r);
    end
  end

  // Apply inputs for one edge and queue the outputs expected after that edge.
  task automatic step(input logic rst, input logic v, input logic [7:0] ins,
                      input logic [1:0] ea, input logic [1:0] eb,
                      input logic [3:0] ed, input logic ee, input logic er);
    exp_t x;
    reset = rst; instr_valid = v; instr = ins;
    x.cyc = cyc + 1; x.tag = tag; x.a = ea; x.b = eb; x.d = ed; x.e = ee; x.r = er;
    q.push_back(x);
    tag = tag + 1;
    @(posedge clock); #1;
  endtask

  initial begin
    // reset held two cycles
    step(1, 0, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    step(1, 0, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    step(0, 0, 8'h00, 2'b10, 2'b10, 4'h0, 0, 1);
    // LDA 5, LDB A back to back
    step(0, 1, 8'h25, 2'b01, 2'b10, 4'h5, 0, 1);
    step(0, 1, 8'h3A, 2'b10, 2'b01, 4'hA, 0, 1);
    step(0, 0, 8'h00, 2'b10, 2'b10, 4'hA, 0, 1);
    // SHLA 3 with LDB 3 held valid through the stall
    step(0, 1, 8'h43, 2'b11, 2'b10, 4'hA, 0, 0);
    step(0, 1, 8'h33, 2'b11, 2'b10, 4'hA, 0, 0);
    step(0, 1, 8'h33, 2'b11, 2'b10, 4'hA, 0, 1);
    step(0, 1, 8'h33, 2'b10, 2'b01, 4'h3, 0, 1);
    // SHLB 0 and SHLB 1
    step(0, 1, 8'h60, 2'b10, 2'b10, 4'h3, 0, 1);
    step(0, 1, 8'h61, 2'b10, 2'b11, 4'h3, 0, 1);
    step(0, 0, 8'h00, 2'b10, 2'b10, 4'h3, 0, 1);
    // clears and NOP
    step(0, 1, 8'h10, 2'b00, 2'b10, 4'h3, 0, 1);
    step(0, 1, 8'h50, 2'b10, 2'b00, 4'h3, 0, 1);
    step(0, 1, 8'h70, 2'b00, 2'b00, 4'h3, 0, 1);
    step(0, 1, 8'h0F, 2'b10, 2'b10, 4'h3, 0, 1);
    // SHLB 2 then LDA 9 issues with no bubble
    step(0, 1, 8'h62, 2'b10, 2'b11, 4'h3, 0, 0);
    step(0, 1, 8'h29, 2'b10, 2'b11, 4'h3, 0, 1);
    step(0, 1, 8'h29, 2'b01, 2'b10, 4'h9, 0, 1);
    // illegal opcode, then legal LDA 1 keeps error set
    step(0, 1, 8'hA7, 2'b10, 2'b10, 4'h9, 1, 1);
    step(0, 1, 8'h21, 2'b01, 2'b10, 4'h1, 1, 1);
    step(0, 0, 8'h00, 2'b10, 2'b10, 4'h1, 1, 1);
    // SHLA 15 aborted by reset at cycle 5
    step(0, 1, 8'h4F, 2'b11, 2'b10, 4'h1, 1, 0);
    step(0, 0, 8'h00, 2'b11, 2'b10, 4'h1, 1, 0);
    step(0, 0, 8'h00, 2'b11, 2'b10, 4'h1, 1, 0);
    step(0, 0, 8'h00, 2'b11, 2'b10, 4'h1, 1, 0);
    step(1, 0, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    step(1, 0, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    step(0, 0, 8'h00, 2'b10, 2'b10, 4'h0, 0, 1);
    step(0, 0, 8'h00, 2'b10, 2'b10, 4'h0, 0, 1);
    step(0, 0, 8'h00, 2'b10, 2'b10, 4'h0, 0, 1);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clock);
    #2;
    total = total + 1;
    if (q.size() == 0) passed = passed + 1;
    else $display("FAIL drain: got %0d expectations left unchecked, want 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
